// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port 2K x 32 RAM (registered read address, one-cycle
//   read latency) between two native-bus masters. Transactions are arbitrated
//   round-robin and every transaction takes the same IDLE -> ACCESS -> RESP
//   path, so both masters see a uniform two-cycle response latency.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   m0_* / m1_*          native-bus requesters (valid/addr/wdata/wstrb in,
//                        ready/rdata out); wstrb == 0 means read
//   ram_en/we/addr/din   RAM control, driven from registered state only
//   ram_dout             RAM read data, valid the cycle after an enabled access
//   stat_clr             clears the contention counter
//   stat_cnt             saturating count of IDLE cycles with both valids high
//   busy                 high whenever a transaction is in flight
module ram_port_arbiter #(
  parameter int AW = 11,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_valid,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout,
  input  logic          stat_clr,
  output logic [CW-1:0] stat_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;     // 0 = m0, 1 = m1
  logic          last_q, last_d;   // master that completed most recently
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          both_req;

  assign both_req = m0_valid & m1_valid;

  // NOTE: every signal gets its hold value before the case statement, so no
  // path through this block leaves a variable unassigned and no latch is
  // inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          // A lone requester always wins; under contention the master that
          // did not complete last is served.
          gnt_d   = both_req ? ~last_q : m1_valid;
          addr_d  = gnt_d ? m1_addr[AW+1:2] : m0_addr[AW+1:2];
          wdata_d = gnt_d ? m1_wdata : m0_wdata;
          wstrb_d = gnt_d ? m1_wstrb : m0_wstrb;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over increment; increment stops at all ones.
    if (stat_clr) begin
      cnt_d = '0;
    end else if (state_q == IDLE && both_req && !(&cnt_q)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      // NOTE: the holding registers are reset too, because they drive the
      // RAM address/data pins directly and those should not float to X.
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM side: purely from state and holding registers.
  assign ram_en   = (state_q == ACCESS);
  assign ram_we   = ram_en ? wstrb_q : 4'b0000;
  assign ram_addr = addr_q;
  assign ram_din  = wdata_q;

  // Master side: the RAM output register holds the word during RESP.
  assign m0_ready = (state_q == RESP) && !gnt_q;
  assign m1_ready = (state_q == RESP) && gnt_q;
  assign m0_rdata = m0_ready ? ram_dout : 32'h0;
  assign m1_rdata = m1_ready ? ram_dout : 32'h0;

  assign stat_cnt = cnt_q;
  assign busy     = (state_q != IDLE);

  // Address bits outside the RAM window are decoded upstream.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:AW+2], m0_addr[1:0],
                              m1_addr[31:AW+2], m1_addr[1:0]};

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port program/data RAM (2K x 32, registered read address, one-cycle read latency) between two native-bus requesters.
  - m0 is the picorv32 core.
  - m1 is an auxiliary master, such as a bluetooth-to-RAM buffer writer.
- Sits between the CPU-side SRAM decode and the RAM instance, and replaces the direct smem_* connection and the local smem_ready flop.
- Arbitration is round-robin per transaction. Both masters see a fixed, uniform response latency.

Parameters:
- AW, 11, RAM word-address width; the RAM word address is taken from byte address bits [AW+1:2].
- CW, 16, width of the contention statistics counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0_valid  in  1  m0 request; held with addr/wdata/wstrb stable until m0_ready
- m0_addr  in  32  m0 byte address; the request is already decoded as in-RAM
- m0_wdata  in  32  m0 write data
- m0_wstrb  in  4  m0 byte strobes; 0 = read
- m0_ready  out  1  one-cycle completion pulse to m0
- m0_rdata  out  32  read data, valid while m0_ready=1
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as the m0 equivalents, for m1
- ram_en  out  1  RAM enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  AW  RAM word address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data; valid the cycle after an enabled access
- stat_clr  in  1  clears the contention counter
- stat_cnt  out  CW  saturating count of IDLE cycles in which both valids were high
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst=1 is sampled on the clk rising edge and is synchronous, active-high.
- Reset values:
  - state=IDLE.
  - m0_ready=m1_ready=0 and m0_rdata=m1_rdata=0.
  - ram_en=0, ram_we=0.
  - gnt=0, last=1, so m0 wins the first contention.
  - stat_cnt=0, busy=0.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
  - IDLE:
    - If no valid is high, remain in IDLE.
    - If exactly one valid is high, grant that master.
    - If both valids are high, grant the master that is not `last`.
    - When a grant is made, register the granted master's addr[AW+1:2], wdata and wstrb into holding registers, set gnt, and go to ACCESS.
  - ACCESS (1 cycle):
    - ram_en=1, ram_addr=held address, ram_din=held data, ram_we=held strobes.
    - Go to RESP.
  - RESP (1 cycle):
    - The granted master's ready=1 and its rdata=ram_dout.
    - For writes, rdata=ram_dout is still presented and the master ignores it.
    - Set last=gnt and go to IDLE.
- Decoded RAM outputs:
  - ram_en, ram_we, ram_addr and ram_din are driven from registered state and holding registers only; there is no combinational path from m*_valid.
  - Outside ACCESS: ram_en=0 and ram_we=0.
- Latency:
  - A valid that arrives while the arbiter is in IDLE sees ready 2 cycles later: valid at cycle N, ACCESS at N+1, ready at N+2.
  - A loser under contention sees ready at N+5 at the latest.
- Throughput: at most one transaction every 3 cycles.
- Ready pulses:
  - Exactly one cycle wide.
  - Never asserted to both masters in the same cycle.
  - Never asserted to a master that was not granted.
- Request sampling:
  - After ready, a master deasserts valid in the following cycle.
  - The arbiter samples requests only in IDLE, so a valid still high in the cycle after ready is not a legal input. If it occurs, it is treated as a new request.
- Valid dropped mid-transaction (protocol violation): the transaction still completes and ready is still pulsed. No abort.
- Fairness:
  - Under continuous dual requests, grants alternate m0, m1, m0, m1, ...
  - A lone requester is granted repeatedly regardless of `last`.
- Contention counter:
  - stat_cnt increments by 1 in each IDLE cycle where m0_valid & m1_valid.
  - It saturates at all ones.
  - stat_clr has priority over increment; the counter reads 0 in the next cycle.
- Reset mid-operation:
  - rst in ACCESS or RESP returns to IDLE the next cycle with every output at its reset value.
  - No ready is issued for the aborted transaction.
  - A write in progress in ACCESS may or may not reach the RAM, depending on whether the RAM clocks before rst is seen. It is undefined and is not checked.
- Widths: ram_addr is address bits [AW+1:2]. Higher address bits are ignored, because decode is upstream.

Test Plan:
- Single read from m0:
  - Stimulus: preload RAM word 5 = 32'hDEADBEEF; m0_valid=1, addr=32'h14, wstrb=0 at cycle N.
  - Response: ram_en=1, ram_addr=5 at N+1. m0_ready=1, m0_rdata=32'hDEADBEEF at N+2, and only at N+2. m1_ready stays 0.
- Byte write from m1:
  - Stimulus: m1 addr=32'h20, wdata=32'h000000AB, wstrb=4'b0001.
  - Response: ram_we=4'b0001, ram_addr=8 at N+1. m1_ready at N+2. A subsequent m0 read of 32'h20 returns low byte 8'hAB with the upper bytes unchanged.
- Simultaneous requests after reset:
  - Stimulus: both valids high at the first IDLE cycle.
  - Response: m0 is served first (ready at N+2). m1 is served next (ready at N+5). stat_cnt=1.
- Continuous contention:
  - Stimulus: both masters re-request immediately for 8 transactions.
  - Response: grants alternate m0,m1,m0,m1,... There is no cycle with both readies high.
- Counter saturation and clear:
  - Stimulus: CW=4, hold both valids high across 20 IDLE cycles.
  - Response: stat_cnt stops at 4'hF. After a stat_clr pulse, stat_cnt reads 0 in the next cycle.
- Reset mid-op:
  - Stimulus: assert rst during RESP of an m0 read.
  - Response: m0_ready=0 in that cycle's successor, state=IDLE, busy=0, last=1. The next dual request is granted to m0.
